// File: rtl/tsc_capture.sv
// Triggered sample capture: stores ADC samples in a ring buffer while armed,
// stamps the trigger time, keeps capturing a fixed number of post-trigger
// samples, then can stream the buffer oldest-first as start/data/stop frames.
module tsc_capture #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned POST_TRIG = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              sbf,
    input  logic [DATA_W-1:0] adc_data,
    input  logic              adc_rdy,
    input  logic [DATA_W-1:0] trigvl,
    input  logic [1:0]        trig_mode,
    output logic              req,
    output logic              trd,
    output logic              cd,
    output logic [31:0]       trigtm,
    output logic              sd,
    output logic              busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned FW = AW + 1;
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [2:0] {
        StIdle,
        StRunning,
        StPost,
        StSendStart,
        StSendData,
        StSendStop
    } state_e;

    state_e            state_q;
    logic [31:0]       timer_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [FW-1:0]     fill_q;
    logic [FW-1:0]     send_left_q;
    logic [AW-1:0]     post_cnt_q;
    logic [DATA_W-1:0] prev_q;
    logic              prev_valid_q;
    logic [DATA_W-1:0] shift_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              trd_q;
    logic              cd_q;
    logic [31:0]       trigtm_q;
    logic              sd_q;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              acq;
    logic              sample_en;
    logic              trig_hit;
    logic [FW-1:0]     fill_inc;
    logic [AW-1:0]     first_idx;
    logic [DATA_W-1:0] rd_data;

    assign acq       = (state_q == StRunning) || (state_q == StPost);
    assign sample_en = acq && adc_rdy;
    assign rd_data   = mem_q[rd_ptr_q];

    // Trigger condition on the current sample; crossing modes need a prior sample.
    always_comb begin
        trig_hit = 1'b0;
        unique case (trig_mode)
            2'd0: trig_hit = adc_data > trigvl;
            2'd1: trig_hit = adc_data < trigvl;
            2'd2: trig_hit = prev_valid_q && (prev_q <= trigvl) && (adc_data > trigvl);
            2'd3: trig_hit = prev_valid_q && (prev_q >= trigvl) && (adc_data < trigvl);
            default: trig_hit = 1'b0;
        endcase
    end

    // Saturating fill count and oldest-sample index for transmission.
    always_comb begin
        fill_inc  = (fill_q == FW'(DEPTH)) ? fill_q : fill_q + 1'b1;
        first_idx = (fill_q == FW'(DEPTH)) ? wr_ptr_q : '0;
    end

    // Sample storage; left unreset since fill gates what is reachable.
    always_ff @(posedge clk) begin
        if (sample_en) begin
            mem_q[wr_ptr_q] <= adc_data;
        end
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            fill_q       <= '0;
            send_left_q  <= '0;
            post_cnt_q   <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            trd_q        <= 1'b0;
            cd_q         <= 1'b0;
            trigtm_q     <= '0;
            sd_q         <= 1'b1;
        end else begin
            if (acq) begin
                timer_q <= timer_q + 32'd1;
            end
            if (sample_en) begin
                wr_ptr_q     <= wr_ptr_q + 1'b1;
                fill_q       <= fill_inc;
                prev_q       <= adc_data;
                prev_valid_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StRunning;
                        timer_q      <= '0;
                        wr_ptr_q     <= '0;
                        fill_q       <= '0;
                        trd_q        <= 1'b0;
                        cd_q         <= 1'b0;
                        prev_q       <= '0;
                        prev_valid_q <= 1'b0;
                    end else if (sbf) begin
                        if (fill_q != '0) begin
                            state_q     <= StSendStart;
                            cd_q        <= 1'b0;
                            sd_q        <= 1'b0;
                            rd_ptr_q    <= first_idx;
                            send_left_q <= fill_q;
                        end else begin
                            cd_q <= 1'b1;
                        end
                    end
                end
                StRunning: begin
                    if (adc_rdy && trig_hit) begin
                        trigtm_q   <= timer_q;
                        post_cnt_q <= AW'(POST_TRIG);
                        if (POST_TRIG == 0) begin
                            state_q <= StIdle;
                            trd_q   <= 1'b1;
                        end else begin
                            state_q <= StPost;
                        end
                    end
                end
                StPost: begin
                    if (adc_rdy) begin
                        post_cnt_q <= post_cnt_q - 1'b1;
                        if (post_cnt_q == AW'(1)) begin
                            state_q <= StIdle;
                            trd_q   <= 1'b1;
                        end
                    end
                end
                StSendStart: begin
                    shift_q   <= rd_data;
                    sd_q      <= rd_data[DATA_W-1];
                    bit_cnt_q <= BW'(DATA_W - 1);
                    state_q   <= StSendData;
                end
                StSendData: begin
                    if (bit_cnt_q == '0) begin
                        sd_q    <= 1'b1;
                        state_q <= StSendStop;
                    end else begin
                        shift_q   <= {shift_q[DATA_W-2:0], 1'b0};
                        sd_q      <= shift_q[DATA_W-2];
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                StSendStop: begin
                    if (send_left_q == FW'(1)) begin
                        state_q <= StIdle;
                        cd_q    <= 1'b1;
                    end else begin
                        send_left_q <= send_left_q - 1'b1;
                        rd_ptr_q    <= rd_ptr_q + 1'b1;
                        sd_q        <= 1'b0;
                        state_q     <= StSendStart;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req    = acq;
    assign busy   = (state_q != StIdle);
    assign trd    = trd_q;
    assign cd     = cd_q;
    assign trigtm = trigtm_q;
    assign sd     = sd_q;

endmodule

// File: tb/tb_tsc_capture.sv
// Directed bench for tsc_capture: acquisition, trigger modes, ring wrap,
// serial readout framing, and reset abort.
module tb_tsc_capture;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        sbf;
    logic [7:0]  adc_data;
    logic        adc_rdy;
    logic [7:0]  trigvl;
    logic [1:0]  trig_mode;
    logic        req;
    logic        trd;
    logic        cd;
    logic [31:0] trigtm;
    logic        sd;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [7:0] hist[$];
    logic [7:0] rx [64];
    int nrx;
    int framing_bad;
    int cycles;

    tsc_capture #(
        .DATA_W   (8),
        .DEPTH    (32),
        .POST_TRIG(16)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .sbf      (sbf),
        .adc_data (adc_data),
        .adc_rdy  (adc_rdy),
        .trigvl   (trigvl),
        .trig_mode(trig_mode),
        .req      (req),
        .trd      (trd),
        .cd       (cd),
        .trigtm   (trigtm),
        .sd       (sd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        hist.delete();
    endtask

    task automatic push(input logic [7:0] d, input int gap);
        adc_data = d;
        adc_rdy  = 1'b1;
        tick();
        adc_rdy  = 1'b0;
        hist.push_back(d);
        repeat (gap) tick();
    endtask

    // Collect frames while busy; bounded at 40 frames.
    task automatic recv();
        logic [7:0] b;
        nrx = 0;
        framing_bad = 0;
        cycles = 0;
        b = '0;
        while (busy === 1'b1 && nrx < 40) begin
            if (sd !== 1'b0) framing_bad++;
            tick();
            for (int k = 0; k < 8; k++) begin
                b = {b[6:0], sd};
                tick();
            end
            if (sd !== 1'b1) framing_bad++;
            rx[nrx] = b;
            nrx++;
            tick();
            cycles += 10;
        end
    endtask

    // Send and compare against the last min(n, 32) pushed samples.
    task automatic send_and_compare(input string tag);
        int n_exp;
        int mism;
        sbf = 1'b1;
        tick();
        sbf = 1'b0;
        chk({tag, "_cd_low"}, 32'(cd), 32'd0);
        recv();
        n_exp = (hist.size() > 32) ? 32 : hist.size();
        mism = 0;
        for (int k = 0; k < n_exp && k < nrx; k++) begin
            if (rx[k] !== hist[hist.size() - n_exp + k]) mism++;
        end
        chk({tag, "_frames"}, 32'(nrx), 32'(n_exp));
        chk({tag, "_framing"}, 32'(framing_bad), 32'd0);
        chk({tag, "_bytes"}, 32'(mism), 32'd0);
        chk({tag, "_cd_done"}, 32'(cd), 32'd1);
        chk({tag, "_sd_idle"}, 32'(sd), 32'd1);
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        sbf       = 1'b0;
        adc_data  = '0;
        adc_rdy   = 1'b0;
        trigvl    = '0;
        trig_mode = 2'd0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_req", 32'(req), 32'd0);
        chk("rst_trd", 32'(trd), 32'd0);
        chk("rst_cd", 32'(cd), 32'd0);
        chk("rst_trigtm", trigtm, 32'd0);
        chk("rst_sd", 32'(sd), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);

        // Ramp in steps of 0x10 every 4th cycle, mode 0 above 0xD0.
        trig_mode = 2'd0;
        trigvl    = 8'hD0;
        do_start();
        chk("t1_req", 32'(req), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 30; i++) push(8'(i * 16), 3);
        chk("t1_trigtm", trigtm, 32'd56);
        chk("t1_trd_pre", 32'(trd), 32'd0);
        chk("t1_req_pre", 32'(req), 32'd1);
        push(8'(30 * 16), 3);
        chk("t1_trd", 32'(trd), 32'd1);
        chk("t1_req_done", 32'(req), 32'd0);
        send_and_compare("t1");
        chk("t1_first", 32'(rx[0]), 32'h00);
        chk("t1_last", 32'(rx[30]), 32'hE0);
        chk("t1_cycles", 32'(cycles), 32'd310);
        chk("t1_trd_hold", 32'(trd), 32'd1);
        send_and_compare("t1_resend");

        // Rising crossing must ignore the first sample after start.
        trig_mode = 2'd2;
        trigvl    = 8'h80;
        do_start();
        chk("t2_cd_clr", 32'(cd), 32'd0);
        chk("t2_trd_clr", 32'(trd), 32'd0);
        push(8'h90, 3);
        chk("t2_no_first", trigtm, 32'd56);
        push(8'h70, 3);
        chk("t2_no_below", trigtm, 32'd56);
        push(8'h85, 3);
        chk("t2_trigtm", trigtm, 32'd8);
        for (int i = 0; i < 15; i++) push(8'h85, 0);
        chk("t2_trd_pre", 32'(trd), 32'd0);
        push(8'h85, 0);
        chk("t2_trd", 32'(trd), 32'd1);

        // Ring wrap: 40 samples then a below-threshold trigger.
        trig_mode = 2'd1;
        trigvl    = 8'h10;
        do_start();
        for (int i = 0; i < 40; i++) push(8'(8'h20 + i), 0);
        chk("t3_trd_none", 32'(trd), 32'd0);
        push(8'h05, 0);
        chk("t3_trigtm", trigtm, 32'd40);
        for (int j = 0; j < 16; j++) push(8'(8'h50 + j), 0);
        chk("t3_trd", 32'(trd), 32'd1);
        send_and_compare("t3");
        chk("t3_oldest", 32'(rx[0]), 32'h39);

        // Empty buffer after reset: sbf completes immediately, sd stays high.
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        sbf = 1'b1;
        tick();
        sbf = 1'b0;
        chk("t4_cd", 32'(cd), 32'd1);
        chk("t4_busy", 32'(busy), 32'd0);
        begin
            int sd_low = 0;
            for (int k = 0; k < 5; k++) begin
                if (sd !== 1'b1) sd_low++;
                tick();
            end
            chk("t4_sd_quiet", 32'(sd_low), 32'd0);
        end
        start = 1'b1;
        sbf   = 1'b1;
        tick();
        start = 1'b0;
        sbf   = 1'b0;
        hist.delete();
        chk("t4_prio_req", 32'(req), 32'd1);
        chk("t4_prio_cd", 32'(cd), 32'd0);

        // Abort a transfer with reset during the data bits of byte 5.
        trig_mode = 2'd0;
        trigvl    = 8'h00;
        for (int i = 0; i < 17; i++) push(8'(8'hA0 + i), 0);
        chk("t5_trd", 32'(trd), 32'd1);
        sbf = 1'b1;
        tick();
        sbf = 1'b0;
        repeat (54) tick();
        chk("t5_busy_pre", 32'(busy), 32'd1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("t5_abort_sd", 32'(sd), 32'd1);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        chk("t5_abort_cd", 32'(cd), 32'd0);
        chk("t5_abort_trd", 32'(trd), 32'd0);
        chk("t5_abort_trigtm", trigtm, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("t5_post_busy", 32'(busy), 32'd0);
        chk("t5_post_sd", 32'(sd), 32'd1);
        sbf = 1'b1;
        tick();
        sbf = 1'b0;
        chk("t5_empty_cd", 32'(cd), 32'd1);
        chk("t5_empty_busy", 32'(busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
